// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and bus widths.
package instruction_cache_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned MEM_ADDR_W      = 28;
  localparam int unsigned OFFSET_W        = 2;
  localparam int unsigned WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/icache_controller.sv
// Miss-handling FSM: latches the missing block address, runs the memory handshake and
// signals the line fill. MEM_READ is registered so memory sees a glitch-free request.
module icache_controller
  import instruction_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic                  i_hit,
  input  logic                  i_mem_busywait,
  input  logic [MEM_ADDR_W-1:0] i_block_addr,
  output state_t                o_state,
  output logic                  o_mem_read,
  output logic [MEM_ADDR_W-1:0] o_miss_addr,
  output logic                  o_busywait_c
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_seen_busy;
  logic                  w_seen_busy_next;
  logic [MEM_ADDR_W-1:0] r_miss_addr;
  logic [MEM_ADDR_W-1:0] w_miss_addr_next;
  logic                  r_mem_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_seen_busy <= 1'b0;
      r_miss_addr <= '0;
      r_mem_read  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_seen_busy <= w_seen_busy_next;
      r_miss_addr <= w_miss_addr_next;
      r_mem_read  <= (w_next_state == FETCH);
    end
  end

  // Completion needs memory to have gone busy first; an early low busywait is ignored.
  always_comb begin
    w_next_state     = r_state;
    w_seen_busy_next = r_seen_busy;
    w_miss_addr_next = r_miss_addr;
    o_busywait_c     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_read && !i_hit) begin
          o_busywait_c     = 1'b1;
          w_miss_addr_next = i_block_addr;
          w_seen_busy_next = 1'b0;
          w_next_state     = FETCH;
        end
      end
      FETCH: begin
        o_busywait_c = 1'b1;
        if (i_mem_busywait) begin
          w_seen_busy_next = 1'b1;
        end else if (r_seen_busy) begin
          w_seen_busy_next = 1'b0;
          w_next_state     = UPDATE;
        end
      end
      UPDATE: begin
        o_busywait_c = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign o_state     = r_state;
  assign o_mem_read  = r_mem_read;
  assign o_miss_addr = r_miss_addr;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with zero-cycle hits and 16-byte line fills.
// Optional hit/miss counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int unsigned CACHE_LINES = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  READ,
  input  logic [31:0]           PC,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]           HIT_COUNT,
  output logic [31:0]           MISS_COUNT
`endif
);

  localparam int unsigned IDX_W = $clog2(CACHE_LINES);
  localparam int unsigned TAG_W = MEM_ADDR_W - IDX_W;

  logic [CACHE_LINES-1:0]          r_valid;
  logic [TAG_W-1:0]                r_tag  [CACHE_LINES];
  logic [BLOCK_W-1:0]              r_data [CACHE_LINES];

  logic [MEM_ADDR_W-1:0]           w_block_addr;
  logic [IDX_W-1:0]                w_index;
  logic [TAG_W-1:0]                w_tag;
  logic [OFFSET_W-1:0]             w_offset;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] w_line;
  logic                            w_hit;
  logic                            w_busywait;
  state_t                          w_state;
  logic [MEM_ADDR_W-1:0]           w_miss_addr;
  logic [IDX_W-1:0]                w_fill_index;
  logic [TAG_W-1:0]                w_fill_tag;
  logic                            w_fill_en;
  logic                            w_unused;

  assign w_block_addr = PC[31:4];
  assign w_index      = w_block_addr[IDX_W-1:0];
  assign w_tag        = w_block_addr[MEM_ADDR_W-1:IDX_W];
  assign w_offset     = PC[3:2];
  assign w_unused     = ^PC[1:0];

  assign w_line = r_data[w_index];
  assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);

  icache_controller u_ctrl (
    .clk            (CLK),
    .rst_n          (RESET_N),
    .i_read         (READ),
    .i_hit          (w_hit),
    .i_mem_busywait (MEM_BUSYWAIT),
    .i_block_addr   (w_block_addr),
    .o_state        (w_state),
    .o_mem_read     (MEM_READ),
    .o_miss_addr    (w_miss_addr),
    .o_busywait_c   (w_busywait)
  );

  // Outputs toward the CPU are forced quiet while reset is held.
  assign BUSYWAIT    = RESET_N & w_busywait;
  assign INSTRUCTION = RESET_N ? w_line[w_offset] : '0;
  assign MEM_ADDRESS = w_miss_addr;

  // The fill targets the latched miss address, never the live PC.
  assign w_fill_en    = (w_state == UPDATE);
  assign w_fill_index = w_miss_addr[IDX_W-1:0];
  assign w_fill_tag   = w_miss_addr[MEM_ADDR_W-1:IDX_W];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid <= '0;
    end else if (w_fill_en) begin
      r_valid[w_fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill_en) begin
      r_data[w_fill_index] <= MEM_READDATA;
      r_tag[w_fill_index]  <= w_fill_tag;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic r_post_update;

  // The re-evaluation cycle right after a fill is not counted as a hit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_post_update <= 1'b0;
      HIT_COUNT     <= '0;
      MISS_COUNT    <= '0;
    end else begin
      r_post_update <= (w_state == UPDATE);
      if ((w_state == IDLE) && READ && !w_hit && (MISS_COUNT != '1)) begin
        MISS_COUNT <= MISS_COUNT + 32'd1;
      end
      if ((w_state == IDLE) && READ && w_hit && !r_post_update && (HIT_COUNT != '1)) begin
        HIT_COUNT <= HIT_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a behavioural block memory; word n of block a is {a,n}.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         READ = 1'b0;
  logic [31:0]  PC = 32'h0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b0;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  int checks = 0;
  int passes = 0;

  instruction_cache #(.CACHE_LINES(8)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .READ         (READ),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory model: optional idle cycles before busy, then MEM_LAT busy cycles, then data.
  localparam int MEM_LAT = 5;
  int          mem_pre = 0;
  int          mem_cnt = 0;
  bit          mem_act = 1'b0;
  logic [27:0] mem_addr = '0;

  function automatic logic [127:0] block_of(input logic [27:0] a);
    return {{2'b00, a, 2'd3}, {2'b00, a, 2'd2}, {2'b00, a, 2'd1}, {2'b00, a, 2'd0}};
  endfunction

  always @(posedge CLK) begin
    #1;
    if (!RESET_N) begin
      mem_act      = 1'b0;
      MEM_BUSYWAIT = 1'b0;
    end else if (mem_act) begin
      mem_cnt++;
      if (mem_cnt <= mem_pre) begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = {4{32'hDEADBEEF}};
      end else if (mem_cnt <= mem_pre + MEM_LAT) begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = {4{32'hDEADBEEF}};
      end else begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = block_of(mem_addr);
        mem_act      = 1'b0;
      end
    end else if (MEM_READ) begin
      mem_act      = 1'b1;
      mem_cnt      = 1;
      mem_addr     = MEM_ADDRESS;
      MEM_BUSYWAIT = (mem_pre == 0);
      MEM_READDATA = {4{32'hDEADBEEF}};
    end
  end

  task automatic wait_ready(output int cycles, output bit timeout);
    cycles  = 0;
    timeout = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      #1;
      cycles++;
      if (BUSYWAIT === 1'b0) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    READ    = 1'b1;
    PC      = 32'h0;
    #1;
    checks++; if (BUSYWAIT !== 1'b0) $display("FAIL reset_busywait got %b want 0", BUSYWAIT); else passes++;
    checks++; if (MEM_READ !== 1'b0) $display("FAIL reset_mem_read got %b want 0", MEM_READ); else passes++;
    checks++; if (MEM_ADDRESS !== 28'h0) $display("FAIL reset_mem_address got %h want 0", MEM_ADDRESS); else passes++;
    checks++; if (INSTRUCTION !== 32'h0) $display("FAIL reset_instruction got %h want 0", INSTRUCTION); else passes++;
    repeat (2) @(negedge CLK);
    READ    = 1'b0;
    RESET_N = 1'b1;
  endtask

  task automatic test_cold_miss();
    int cyc;
    bit to;
    @(negedge CLK);
    READ = 1'b1;
    PC   = 32'h0;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) $display("FAIL cold_busy_same_cycle got %b want 1", BUSYWAIT); else passes++;
    checks++; if (MEM_READ !== 1'b0) $display("FAIL cold_mem_read_early got %b want 0", MEM_READ); else passes++;
    @(negedge CLK);
    #1;
    checks++; if (MEM_READ !== 1'b1) $display("FAIL cold_mem_read got %b want 1", MEM_READ); else passes++;
    checks++; if (MEM_ADDRESS !== 28'h0000000) $display("FAIL cold_mem_address got %h want 0000000", MEM_ADDRESS); else passes++;
    checks++; if (BUSYWAIT !== 1'b1) $display("FAIL cold_busy_fetch got %b want 1", BUSYWAIT); else passes++;
    wait_ready(cyc, to);
    checks++; if (to !== 1'b0) $display("FAIL cold_timeout got %b want 0", to); else passes++;
    checks++; if (cyc !== 7) $display("FAIL cold_stall_cycles got %0d want 7", cyc); else passes++;
    checks++; if (INSTRUCTION !== 32'h0) $display("FAIL cold_instruction got %h want 00000000", INSTRUCTION); else passes++;
    checks++; if (MEM_READ !== 1'b0) $display("FAIL cold_mem_read_done got %b want 0", MEM_READ); else passes++;
  endtask

  task automatic test_hits();
    logic [31:0] pcs [3];
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      PC = pcs[i];
      #1;
      checks++; if (BUSYWAIT !== 1'b0) $display("FAIL hit_busy pc=%h got %b want 0", pcs[i], BUSYWAIT); else passes++;
      checks++; if (INSTRUCTION !== 32'(i + 1)) $display("FAIL hit_instruction pc=%h got %h want %h", pcs[i], INSTRUCTION, 32'(i + 1)); else passes++;
      checks++; if (MEM_READ !== 1'b0) $display("FAIL hit_mem_read pc=%h got %b want 0", pcs[i], MEM_READ); else passes++;
    end
    @(negedge CLK);
    #1;
`ifdef ICACHE_PERF_COUNTERS_EN
    checks++; if (MISS_COUNT !== 32'd1) $display("FAIL perf_miss_count got %0d want 1", MISS_COUNT); else passes++;
    checks++; if (HIT_COUNT !== 32'd3) $display("FAIL perf_hit_count got %0d want 3", HIT_COUNT); else passes++;
`endif
    READ = 1'b0;
  endtask

  task automatic test_conflict();
    int cyc;
    bit to;
    @(negedge CLK);
    READ = 1'b1;
    PC   = 32'h80;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) $display("FAIL conflict_busy got %b want 1", BUSYWAIT); else passes++;
    @(negedge CLK);
    #1;
    checks++; if (MEM_ADDRESS !== 28'h0000008) $display("FAIL conflict_mem_address got %h want 0000008", MEM_ADDRESS); else passes++;
    checks++; if (MEM_READ !== 1'b1) $display("FAIL conflict_mem_read got %b want 1", MEM_READ); else passes++;
    wait_ready(cyc, to);
    checks++; if (to !== 1'b0) $display("FAIL conflict_timeout got %b want 0", to); else passes++;
    checks++; if (INSTRUCTION !== 32'h20) $display("FAIL conflict_instruction got %h want 00000020", INSTRUCTION); else passes++;
    @(negedge CLK);
    PC = 32'h0;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) $display("FAIL evicted_busy got %b want 1", BUSYWAIT); else passes++;
    wait_ready(cyc, to);
    checks++; if (to !== 1'b0) $display("FAIL evicted_timeout got %b want 0", to); else passes++;
    checks++; if (INSTRUCTION !== 32'h0) $display("FAIL evicted_instruction got %h want 00000000", INSTRUCTION); else passes++;
  endtask

  task automatic test_late_busy();
    int cyc;
    bit to;
    mem_pre = 2;
    @(negedge CLK);
    READ = 1'b1;
    PC   = 32'h114;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      #1;
      checks++; if (MEM_READ !== 1'b1) $display("FAIL late_mem_read cyc=%0d got %b want 1", i, MEM_READ); else passes++;
      checks++; if (BUSYWAIT !== 1'b1) $display("FAIL late_busy cyc=%0d got %b want 1", i, BUSYWAIT); else passes++;
    end
    wait_ready(cyc, to);
    checks++; if (to !== 1'b0) $display("FAIL late_timeout got %b want 0", to); else passes++;
    checks++; if (INSTRUCTION !== 32'h45) $display("FAIL late_instruction got %h want 00000045", INSTRUCTION); else passes++;
    mem_pre = 0;
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    bit to;
    @(negedge CLK);
    READ = 1'b1;
    PC   = 32'h200;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++; if (MEM_READ !== 1'b1) $display("FAIL midrst_pre_mem_read got %b want 1", MEM_READ); else passes++;
    RESET_N = 1'b0;
    #1;
    checks++; if (MEM_READ !== 1'b0) $display("FAIL midrst_mem_read got %b want 0", MEM_READ); else passes++;
    checks++; if (BUSYWAIT !== 1'b0) $display("FAIL midrst_busy got %b want 0", BUSYWAIT); else passes++;
    checks++; if (MEM_ADDRESS !== 28'h0) $display("FAIL midrst_mem_address got %h want 0", MEM_ADDRESS); else passes++;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    PC      = 32'h0;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) $display("FAIL midrst_valid_cleared got %b want 1", BUSYWAIT); else passes++;
    wait_ready(cyc, to);
    checks++; if (to !== 1'b0) $display("FAIL midrst_refill_timeout got %b want 0", to); else passes++;
    checks++; if (INSTRUCTION !== 32'h0) $display("FAIL midrst_refill_instruction got %h want 00000000", INSTRUCTION); else passes++;
    @(negedge CLK);
    PC = 32'h200;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) $display("FAIL midrst_abandoned_busy got %b want 1", BUSYWAIT); else passes++;
    wait_ready(cyc, to);
    checks++; if (INSTRUCTION !== 32'h80) $display("FAIL midrst_abandoned_instruction got %h want 00000080", INSTRUCTION); else passes++;
  endtask

  task automatic test_read_low();
    @(negedge CLK);
    READ = 1'b0;
    PC   = 32'h300;
    #1;
    checks++; if (BUSYWAIT !== 1'b0) $display("FAIL readlow_busy got %b want 0", BUSYWAIT); else passes++;
    @(negedge CLK);
    #1;
    checks++; if (MEM_READ !== 1'b0) $display("FAIL readlow_mem_read got %b want 0", MEM_READ); else passes++;
    checks++; if (BUSYWAIT !== 1'b0) $display("FAIL readlow_busy_next got %b want 0", BUSYWAIT); else passes++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_late_busy();
    test_reset_mid_fetch();
    test_read_low();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
